// File: rtl/spi_request_arbiter_pkg.sv
// spi_request_arbiter_pkg: shared widths, rw encoding and arbiter FSM states
package spi_request_arbiter_pkg;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 20;
    typedef enum logic {RW_WRITE = 1'b0, RW_READ = 1'b1} rw_e;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMPLETE  = 3'd4
    } arb_state_e;
endpackage

// File: rtl/spi_request_arbiter_if.sv
// spi_request_arbiter_if: requester and SPI controller signals of the arbiter
// slave modport = arbiter side, master modport = requesters + controller side
//   i_req/i_rw/i_addr/i_wdata : packed per-requester commands
//   o_ack/o_err/o_rdata/o_busy: completion side back to requesters
//   o_spi_*/i_spi_*           : controller start/command and ready/read data
interface spi_request_arbiter_if
    import spi_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SPI_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SPI_DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]                i_req;
    logic [NUM_REQ-1:0]                i_rw;
    logic [NUM_REQ*SPI_ADDR_WIDTH-1:0] i_addr;
    logic [NUM_REQ*SPI_DATA_WIDTH-1:0] i_wdata;
    logic [NUM_REQ-1:0]                o_ack;
    logic                              o_err;
    logic [SPI_DATA_WIDTH-1:0]         o_rdata;
    logic                              o_busy;
    logic                              o_spi_start;
    logic                              o_spi_rw;
    logic [SPI_ADDR_WIDTH-1:0]         o_spi_addr;
    logic [SPI_DATA_WIDTH-1:0]         o_spi_wdata;
    logic                              i_spi_ready;
    logic [SPI_DATA_WIDTH-1:0]         i_spi_rdata;
    modport slave (
        input  i_req, i_rw, i_addr, i_wdata, i_spi_ready, i_spi_rdata,
        output o_ack, o_err, o_rdata, o_busy, o_spi_start, o_spi_rw, o_spi_addr, o_spi_wdata
    );
    modport master (
        output i_req, i_rw, i_addr, i_wdata, i_spi_ready, i_spi_rdata,
        input  o_ack, o_err, o_rdata, o_busy, o_spi_start, o_spi_rw, o_spi_addr, o_spi_wdata
    );
endinterface

// File: rtl/spi_request_arbiter_rr_pick.sv
// spi_request_arbiter_rr_pick: combinational round-robin pick, first set req at or after ptr
//   req_i   : request vector
//   ptr_i   : index where the ascending, wrapping scan starts
//   idx_o   : winning index
//   found_o : any request set
module spi_request_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);
    logic [2*N-1:0] rot;
    always_comb begin
        rot     = {req_i, req_i} >> ptr_i;
        idx_o   = '0;
        found_o = |req_i;
        // descending so the smallest offset from ptr is written last and wins
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) idx_o = IW'((int'(ptr_i) + i) % N);
    end
endmodule

// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter: round-robin sharing of one SPI controller, one transaction at a time
//   i_clk_sys : system clock
//   i_rst_n   : asynchronous active-low reset
//   bus       : requester commands/acks and controller handshake (slave modport)
module spi_request_arbiter
    import spi_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SPI_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SPI_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  i_clk_sys,
    input logic                  i_rst_n,
    spi_request_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    arb_state_e                state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d, idx_q, idx_d, win;
    logic                      found, rw_q, rw_d, to_q, to_d, wd_exp, sel_rw;
    logic [SPI_ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr;
    logic [SPI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, sel_wdata;
    logic [WW-1:0]             wd_q, wd_d;

    spi_request_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i  (bus.i_req),
        .ptr_i  (ptr_q),
        .idx_o  (win),
        .found_o(found)
    );

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == IW'(i)) begin
                sel_rw    = bus.i_rw[i];
                sel_addr  = bus.i_addr[i*SPI_ADDR_WIDTH +: SPI_ADDR_WIDTH];
                sel_wdata = bus.i_wdata[i*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
            end
    end

    assign wd_exp = wd_q == WW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE:
                if (found && bus.i_spi_ready) begin
                    state_d = ST_ISSUE;
                    idx_d   = win;
                    ptr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    to_d    = 1'b0;
                end
            ST_ISSUE: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY:
                if (!bus.i_spi_ready) state_d = ST_WAIT_DONE;
                else if (wd_exp) begin
                    state_d = ST_COMPLETE;
                    to_d    = 1'b1;
                end
            ST_WAIT_DONE:
                if (bus.i_spi_ready) begin
                    // capture on the finish edge so o_rdata is already valid in the ack cycle
                    state_d = ST_COMPLETE;
                    rdata_d = (rw_q == RW_READ) ? bus.i_spi_rdata : rdata_q;
                end else if (wd_exp) begin
                    state_d = ST_COMPLETE;
                    to_d    = 1'b1;
                end
            ST_COMPLETE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        wd_d = (state_d != state_q) ? '0 :
               (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) ? wd_q + 1'b1 : '0;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
            wd_q    <= wd_d;
        end
    end

    assign bus.o_busy      = state_q != ST_IDLE;
    assign bus.o_spi_start = state_q == ST_ISSUE;
    assign bus.o_ack       = (state_q == ST_COMPLETE) ? NUM_REQ'(1) << idx_q : '0;
    assign bus.o_err       = (state_q == ST_COMPLETE) && to_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_spi_rw    = rw_q;
    assign bus.o_spi_addr  = addr_q;
    assign bus.o_spi_wdata = wdata_q;
endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb_spi_request_arbiter: directed + randomized checks of spi_request_arbiter against a behavioural model
module tb_spi_request_arbiter;
    import spi_request_arbiter_pkg::*;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 20;
    localparam int T  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_request_arbiter_if #(.NUM_REQ(N), .SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW)) bus ();
    spi_request_arbiter #(
        .NUM_REQ(N), .SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk_sys(clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    logic [DW-1:0] mrd = '0;
    logic          mrw  [N];
    logic [AW-1:0] maddr[N];
    logic [DW-1:0] mwd  [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // requester k wins if it is the first asserted one met walking upward from ptr, wrapping
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    task automatic set_cmd(input int k, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mrw[k] = rw;
        maddr[k] = a;
        mwd[k] = d;
        bus.i_rw[k] = rw;
        bus.i_addr[k*AW +: AW] = a;
        bus.i_wdata[k*DW +: DW] = d;
    endtask

    task automatic rand_cmds();
        for (int k = 0; k < N; k++) set_cmd(k, 1'($urandom), AW'($urandom), DW'($urandom));
    endtask

    // acc = cycles in WAIT_BUSY before the controller accepts (0: never),
    // dn = cycles busy before finishing (0: never)
    task automatic serve(input int acc, input int dn, input logic [DW-1:0] rd, input bit clr, input bit pulse3);
        int w, n;
        bit to_exp;
        w = pick(bus.i_req, mptr);
        mptr = (w + 1) % N;
        to_exp = (acc == 0) || (dn == 0);
        n = 0;
        while (bus.o_spi_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start", bus.o_spi_start, 1);
        chk("busy_at_start", bus.o_busy, 1);
        chk("spi_rw", bus.o_spi_rw, mrw[w]);
        chk("spi_addr", bus.o_spi_addr, maddr[w]);
        chk("spi_wdata", bus.o_spi_wdata, mwd[w]);
        if (pulse3) bus.i_req[3] = 1'b1;
        @(negedge clk);
        if (pulse3) bus.i_req[3] = 1'b0;
        chk("start_once", bus.o_spi_start, 0);
        if (acc > 0) begin
            repeat (acc - 1) @(negedge clk);
            bus.i_spi_ready = 1'b0;
            if (dn > 0) begin
                repeat (dn) @(negedge clk);
                bus.i_spi_rdata = rd;
                bus.i_spi_ready = 1'b1;
            end
        end
        n = 0;
        while (bus.o_ack === '0 && n < T + 10) begin
            @(negedge clk);
            n++;
        end
        if (acc == 0) chk("timeout_cycles", n, T);
        if (!to_exp && mrw[w] == RW_READ) mrd = rd;
        chk("ack", bus.o_ack, 32'(1) << w);
        chk("err", bus.o_err, to_exp);
        chk("rdata", bus.o_rdata, mrd);
        chk("busy_at_ack", bus.o_busy, 1);
        if (clr) bus.i_req = '0;
        bus.i_spi_ready = 1'b1;
        @(negedge clk);
        chk("ack_once", bus.o_ack, 0);
        chk("busy_clear", bus.o_busy, 0);
        chk("rdata_hold", bus.o_rdata, mrd);
    endtask

    initial begin
        int n, seen;
        bus.i_req = '0;
        bus.i_rw = '0;
        bus.i_addr = '0;
        bus.i_wdata = '0;
        bus.i_spi_ready = 1'b1;
        bus.i_spi_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_ack", bus.o_ack, 0);
        chk("rst_start", bus.o_spi_start, 0);
        chk("rst_rdata", bus.o_rdata, 0);
        chk("rst_addr", bus.o_spi_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write
        set_cmd(1, RW_WRITE, 6'h15, 20'hA5A5A);
        bus.i_req = 4'b0010;
        serve(2, 3, 20'h0F0F0, 1, 0);

        // read returns controller data in the ack cycle
        set_cmd(2, RW_READ, 6'h2A, 20'h00000);
        bus.i_req = 4'b0100;
        serve(1, 2, 20'h12345, 1, 0);

        // requester 3 pulses while requester 0 is being served: withdrawal
        set_cmd(0, RW_WRITE, 6'h01, 20'h11111);
        bus.i_req = 4'b0001;
        serve(2, 2, 20'hBEEF1, 1, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_spi_start || bus.o_ack != '0) seen++;
        end
        chk("withdrawn_not_served", seen, 0);

        // all requesting: strict rotation
        rand_cmds();
        bus.i_req = 4'b1111;
        for (int i = 0; i < 8; i++) serve(1 + $urandom_range(0, 2), 1 + $urandom_range(0, 2), DW'($urandom), i == 7, 0);

        // stuck controller: never accepts, then never finishes
        set_cmd(3, RW_READ, 6'h3F, 20'h0);
        bus.i_req = 4'b1000;
        serve(0, 0, 20'hDEAD0, 1, 0);
        bus.i_req = 4'b0100;
        serve(1, 0, 20'hDEAD1, 1, 0);

        // controller busy in IDLE: no grant
        bus.i_spi_ready = 1'b0;
        bus.i_req = 4'b0001;
        repeat (5) @(negedge clk);
        chk("no_grant_not_ready", bus.o_busy, 0);
        bus.i_spi_ready = 1'b1;
        serve(1, 1, DW'($urandom), 1, 0);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            rand_cmds();
            bus.i_req = N'($urandom_range(1, (1 << N) - 1));
            serve(1 + $urandom_range(0, 3), 1 + $urandom_range(0, 3), DW'($urandom), 1, 0);
        end

        // reset while in WAIT_DONE
        set_cmd(2, RW_READ, 6'h07, 20'h0);
        bus.i_req = 4'b0100;
        n = 0;
        while (bus.o_spi_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_start", bus.o_spi_start, 1);
        @(negedge clk);
        bus.i_spi_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_before", bus.o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_ack", bus.o_ack, 0);
        chk("mid_rst_start", bus.o_spi_start, 0);
        chk("mid_rst_err", bus.o_err, 0);
        chk("mid_rst_addr", bus.o_spi_addr, 0);
        chk("mid_rst_rw", bus.o_spi_rw, 0);
        chk("mid_rst_wdata", bus.o_spi_wdata, 0);
        chk("mid_rst_rdata", bus.o_rdata, 0);
        mptr = 0;
        mrd = '0;
        bus.i_req = '0;
        bus.i_spi_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_ack", bus.o_ack, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rand_cmds();
        bus.i_req = 4'b1010;
        serve(1, 1, DW'($urandom), 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
